fifo_byte_serializer: RTL
=========================

FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 Parameter WORD_BYTES, default 4: bytes per FIFO word; legal values 2, 4, 8.
REQ-002 Parameter LEN_W, default 16: width of the transfer length and byte counters.
REQ-003 Parameter BIG_ENDIAN, default 1: 1 = most-significant byte first; 0 = least-significant byte first.
REQ-004 CLK  in  1  clock; all state changes on the rising edge.
REQ-005 RESETn  in  1  asynchronous, active-low reset.
REQ-006 Read_Request  in  1  start request, sampled in IDLE only.
REQ-007 i_length  in  LEN_W  bytes to transfer, latched at start.
REQ-008 i_abort  in  1  terminate the active transfer.
REQ-009 i_FIFO_empty  in  1  FIFO empty flag.
REQ-010 i_FIFO_dout  in  8*WORD_BYTES  first-word-fall-through data, valid while i_FIFO_empty=0.
REQ-011 o_FIFO_rd_en  out  1  pop strobe, combinational, one cycle per word.
REQ-012 o_data  out  8  serialized byte.
REQ-013 i_ready  in  1  downstream accept.
REQ-014 o_valid  out  1  o_data valid.
REQ-015 o_last  out  1  current byte is the final byte of the transfer.
REQ-016 o_busy  out  1  state is not IDLE.
REQ-017 o_done  out  1  one-cycle completion pulse.
REQ-018 o_aborted  out  1  qualifies o_done: transfer ended by abort.
REQ-019 o_byte_sel  out  $clog2(WORD_BYTES)  byte index within the current word.
REQ-020 o_bytes_remaining  out  LEN_W  bytes not yet transferred.

Function
REQ-021 States are IDLE, EMIT and DONE.
REQ-022 In IDLE, Read_Request=1 with i_length!=0 latches remaining=i_length and sets o_byte_sel=0, then moves to EMIT; i_length=0 is ignored and the block stays in IDLE.
REQ-023 In EMIT, o_valid = ~i_FIFO_empty & ~i_abort; o_valid is 0 in IDLE and in DONE.
REQ-024 Byte selection: with BIG_ENDIAN=1, o_data = dout[8*(WORD_BYTES-1-o_byte_sel) +: 8]; with BIG_ENDIAN=0, o_data = dout[8*o_byte_sel +: 8]; o_data is 0 when o_valid=0.
REQ-025 A transfer occurs when o_valid & i_ready; on a transfer, remaining decrements and o_byte_sel increments, wrapping from WORD_BYTES-1 to 0.
REQ-026 While o_valid=1 and i_ready=0, o_data, o_byte_sel and remaining hold (no drop, no pop).
REQ-027 While i_FIFO_empty=1 in EMIT, the block stalls with no timeout and no pop.
REQ-028 o_FIFO_rd_en = transfer & (o_byte_sel==WORD_BYTES-1 | remaining==1); the unused tail of a partial final word is popped and discarded.
REQ-029 Total pops per completed transfer = ceil(i_length/WORD_BYTES).
REQ-030 o_last = o_valid & (remaining==1).
REQ-031 A transfer with remaining==1 moves the block to DONE.
REQ-032 DONE lasts one cycle with o_done=1, then returns to IDLE; Read_Request in DONE is ignored.
REQ-033 i_abort in EMIT moves the block to DONE with o_aborted=1 for the o_done cycle.
REQ-034 On abort, o_FIFO_rd_en=1 that cycle only if o_byte_sel!=0 & ~i_FIFO_empty, keeping the FIFO word-aligned.
REQ-035 i_abort outside EMIT has no effect.
REQ-036 Abort and i_ready in the same cycle: abort wins and no byte is counted.
REQ-037 o_bytes_remaining shows the latched remaining in EMIT and 0 in IDLE.

Reset
REQ-038 RESETn=0 asynchronously forces IDLE and clears remaining, o_byte_sel and all outputs to 0, including o_FIFO_rd_en.
REQ-039 Reset mid-transfer abandons the transfer, pops nothing and produces no o_done.
REQ-040 After RESETn deasserts, the first possible start is at the next rising edge.

Verification
REQ-041 WORD_BYTES=4, BIG_ENDIAN=1, length 8, words 0x11223344 and 0x55667788, i_ready=1: bytes 11 22 33 44 55 66 77 88 on consecutive cycles; rd_en on byte 4 and byte 8; o_last on 88; o_done the next cycle.
REQ-042 Length 6, BIG_ENDIAN=0, same words: bytes 44 33 22 11 88 77; 2 pops, the second on byte 77; 66 and 55 discarded.
REQ-043 i_ready toggled 1,0,0,1 and FIFO empty for 3 cycles mid-word: the output byte sequence is unchanged; o_valid=0 during empty; no duplicate bytes; no extra pops.
REQ-044 Abort at o_byte_sel=2 of word 1 (length 12): rd_en pulses once; o_done=1 with o_aborted=1; the next transfer starts on word 2 with o_byte_sel=0.
REQ-045 RESETn pulsed low mid-word: all outputs 0 immediately, no o_done; a new request of length 4 completes normally.
REQ-046 Parameter sweep WORD_BYTES=2 and 8 with length=WORD_BYTES+1: 2 pops; the final pop is on the last byte; o_byte_sel wraps correctly.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// Serializes first-word-fall-through FIFO words into a byte stream of a latched length.
// Latency: a byte appears combinationally in the cycle after the start request; one byte per cycle.
// Backpressure: i_ready low or FIFO empty holds the current byte; a pop happens only on a word's last transfer.
module fifo_byte_serializer #(
  parameter int WORD_BYTES = 4,
  parameter int LEN_W      = 16,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          Read_Request,
  input  logic [LEN_W-1:0]              i_length,
  input  logic                          i_abort,
  input  logic                          i_FIFO_empty,
  input  logic [8*WORD_BYTES-1:0]       i_FIFO_dout,
  output logic                          o_FIFO_rd_en,
  output logic [7:0]                    o_data,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_aborted,
  output logic [$clog2(WORD_BYTES)-1:0] o_byte_sel,
  output logic [LEN_W-1:0]              o_bytes_remaining
);

  localparam int SEL_W = $clog2(WORD_BYTES);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ab_q, ab_d;
  logic             last_byte;
  logic [SEL_W-1:0] byte_idx;

  assign last_byte = (rem_q == LEN_W'(1));

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      ab_q    <= ab_d;
    end
  end

  // Next-state and handshake logic: abort beats a same-cycle transfer, and an
  // abort inside a partly consumed word pops it so the next transfer starts aligned.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    sel_d        = sel_q;
    ab_d         = ab_q;
    o_valid      = 1'b0;
    o_last       = 1'b0;
    o_FIFO_rd_en = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_aborted    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read_Request && (i_length != '0)) begin
          state_d = S_EMIT;
          rem_d   = i_length;
          sel_d   = '0;
          ab_d    = 1'b0;
        end
      end
      S_EMIT: begin
        o_busy  = 1'b1;
        o_valid = !i_FIFO_empty && !i_abort;
        o_last  = o_valid && last_byte;
        if (i_abort) begin
          o_FIFO_rd_en = (sel_q != '0) && !i_FIFO_empty;
          state_d      = S_DONE;
          ab_d         = 1'b1;
          sel_d        = '0;
        end else if (o_valid && i_ready) begin
          o_FIFO_rd_en = (sel_q == SEL_MAX) || last_byte;
          rem_d        = rem_q - LEN_W'(1);
          sel_d        = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
          if (last_byte) begin
            state_d = S_DONE;
            sel_d   = '0;
          end
        end
      end
      S_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        o_aborted = ab_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte lane select: lane order follows the configured endianness; zero when not valid.
  always_comb begin
    byte_idx = sel_q;
    if (BIG_ENDIAN != 0) begin
      byte_idx = SEL_MAX - sel_q;
    end
    o_data = 8'h00;
    if (o_valid) begin
      o_data = i_FIFO_dout[8*byte_idx +: 8];
    end
  end

  assign o_byte_sel        = sel_q;
  assign o_bytes_remaining = (state_q == S_IDLE) ? '0 : rem_q;

endmodule
